rob_unit: RTL and testbench
===========================

Name: rob_unit

Overview:
- Reorder buffer for the out-of-order MIPS core. It sits between dispatch, the common data bus (CDB) and the architectural register file.
- Integrates three sub-blocks:
  - a register status table (RST): one entry per architectural register, mapping it to its latest in-flight tag;
  - a 32-entry temporary result file indexed by tag;
  - a 32-deep program-order tag FIFO.
- Retires completed instructions strictly in dispatch order, at most one per clock.

Parameters:
- ENTRIES, 32, in-flight instructions / tag space (tag width 5, fixed).
- NREGS, 32, architectural registers (register index width 5, fixed).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- Dispatch_valid  in  1  dispatch strobe for a new instruction.
- Dispatch_Rd_tag  in  5  tag allocated to the new instruction.
- Dispatch_Rd_reg  in  5  destination register.
- Dispatch_pc  in  32  PC; branch target for branches.
- Dispatch_inst_type  in  2  00 = rd-writing, 01 = branch, 10 = store, 11 = reserved (treated as 00 without RST write).
- Rob_full  out  1  order FIFO holds 32 tags.
- Rs_reg, Rt_reg  in  5  source register queries.
- Rs_reg_ren, Rt_reg_ren  in  1  query enables.
- Rs_token, Rt_token  out  6  {tag[4:0], renamed}.
- Rs_Data_spec, Rt_Data_spec  out  32  speculative value of the mapped tag.
- Rs_Data_valid, Rt_Data_valid  out  1  speculative value available.
- Cdb_valid  in  1  CDB broadcast valid.
- Cdb_rd_tag  in  5  completing tag.
- Cdb_data  in  32  result.
- Cdb_branch  in  1  completing instruction is a branch.
- Cdb_branch_taken  in  1  branch must be taken (misprediction).
- Retire_valid  out  1  an instruction retires this cycle.
- Retire_rd_tag  out  5  retired tag.
- Retire_rd_reg  out  5  destination register.
- Retire_data  out  32  result.
- Retire_pc  out  32  stored PC.
- Retire_branch  out  1  retired instruction is a branch.
- Retire_branch_taken  out  1  retired branch was taken.
- Retire_store_ready  out  1  retired instruction is a store.

Behaviour:
- Reset (sync):
  - all RST entries invalid;
  - all result-file entries invalid;
  - FIFO empty (head = tail = count = 0).
  - All registered outputs are 0.
- Rob_full: combinational, count == 32.
- Dispatch (posedge, Dispatch_valid & !Rob_full):
  - Push the tag at the FIFO tail.
  - Write entry[tag] = {rd_reg, pc, type, data = 0, done = 0, taken = 0, valid = 1}.
  - If type == 00 and rd_reg != 0, set RST[rd_reg] = {tag, 1}.
  - Dispatch while full is ignored: no state change.
- Query: combinational, reflects state as of the last clock edge, with no same-cycle bypass.
  - Rs_token = {RST[Rs_reg].tag, RST[Rs_reg].valid}.
  - Rs_Data_spec = entry[RST tag].data.
  - Rs_Data_valid = RST valid & entry done.
  - When Rs_reg_ren = 0, all three Rs outputs are 0. The Rt port behaves identically.
- CDB (posedge, Cdb_valid):
  - If entry[Cdb_rd_tag].valid: set data = Cdb_data, done = 1, taken = Cdb_branch & Cdb_branch_taken.
  - Otherwise the broadcast is ignored.
- Retire (posedge): if FIFO non-empty and entry[head].done:
  - Pop the head and clear entry valid/done.
  - Next cycle: Retire_valid = 1, with Retire_rd_tag/reg/data/pc from the entry.
  - Retire_branch = (type == 01); Retire_branch_taken = entry taken; Retire_store_ready = (type == 10).
  - If RST[rd_reg].valid and RST[rd_reg].tag == retired tag, clear RST valid.
  - Otherwise Retire_valid = 0 and the other Retire_* hold their last values.
- Latency:
  - A CDB write at edge N makes a head entry eligible at edge N+1.
  - Retire_valid is seen after edge N+1, so there is no CDB-to-retire bypass.
- Simultaneous events:
  - Dispatch + retire in one cycle: count unchanged. Full is evaluated before the edge, so dispatch while full is rejected even if a retire occurs in the same cycle.
  - Dispatch and CDB to the same tag: dispatch wins (done = 0).
  - Dispatch RST write and retire RST clear to the same register: dispatch wins.
- FIFO pointers are 5 bits and wrap mod 32; count is 6 bits.
- Mispredicted branches are only reported. Flushing is done externally via reset.

Test Plan:
- Reset, then query Rs_reg = 3 with ren = 1 -> Rs_token = 6'b0, Rs_Data_valid = 0; Rob_full = 0, Retire_valid = 0.
- Dispatch tag 5 -> r3 (type 00), then query r3 -> Rs_token = {5, 1}, valid = 0. Then CDB tag 5 with data 0x1234 -> query gives Rs_Data_spec = 0x1234, valid = 1. Retire pulse: rd_tag 5, rd_reg 3, data 0x1234. After that, query r3 -> token valid = 0.
- Dispatch tags 1, 2, 3 in order; CDB completes 3, then 2, then 1 -> retires occur in the order 1, 2, 3 on consecutive cycles after tag 1 completes.
- Dispatch branch tag 7 with pc 0x400, then CDB tag 7 with Cdb_branch = 1 and taken = 1 -> Retire_branch = 1, taken = 1, Retire_pc = 0x400. Dispatch store tag 8, complete it -> Retire_store_ready = 1.
- Dispatch 32 tags -> Rob_full = 1 and a 33rd dispatch is ignored. Complete and retire the head -> Rob_full = 0. A new dispatch is accepted and the tail pointer wraps.
- Rename r4 with tag 1 then tag 2; complete and retire tag 1 -> RST[r4] remains {2, 1}.

Source files
------------

// File: rtl/rob_unit_if.sv
// Dispatch / query / CDB / retire signal bundle around the reorder buffer.
// slave is the reorder buffer side, master is the core side driving it.
interface rob_unit_if;
    logic        Dispatch_valid;
    logic [4:0]  Dispatch_Rd_tag;
    logic [4:0]  Dispatch_Rd_reg;
    logic [31:0] Dispatch_pc;
    logic [1:0]  Dispatch_inst_type;
    logic        Rob_full;

    logic [4:0]  Rs_reg;
    logic [4:0]  Rt_reg;
    logic        Rs_reg_ren;
    logic        Rt_reg_ren;
    logic [5:0]  Rs_token;
    logic [5:0]  Rt_token;
    logic [31:0] Rs_Data_spec;
    logic [31:0] Rt_Data_spec;
    logic        Rs_Data_valid;
    logic        Rt_Data_valid;

    logic        Cdb_valid;
    logic [4:0]  Cdb_rd_tag;
    logic [31:0] Cdb_data;
    logic        Cdb_branch;
    logic        Cdb_branch_taken;

    logic        Retire_valid;
    logic [4:0]  Retire_rd_tag;
    logic [4:0]  Retire_rd_reg;
    logic [31:0] Retire_data;
    logic [31:0] Retire_pc;
    logic        Retire_branch;
    logic        Retire_branch_taken;
    logic        Retire_store_ready;

    modport master (
        output Dispatch_valid, Dispatch_Rd_tag, Dispatch_Rd_reg, Dispatch_pc, Dispatch_inst_type,
        input  Rob_full,
        output Rs_reg, Rt_reg, Rs_reg_ren, Rt_reg_ren,
        input  Rs_token, Rt_token, Rs_Data_spec, Rt_Data_spec, Rs_Data_valid, Rt_Data_valid,
        output Cdb_valid, Cdb_rd_tag, Cdb_data, Cdb_branch, Cdb_branch_taken,
        input  Retire_valid, Retire_rd_tag, Retire_rd_reg, Retire_data, Retire_pc,
        input  Retire_branch, Retire_branch_taken, Retire_store_ready
    );

    modport slave (
        input  Dispatch_valid, Dispatch_Rd_tag, Dispatch_Rd_reg, Dispatch_pc, Dispatch_inst_type,
        output Rob_full,
        input  Rs_reg, Rt_reg, Rs_reg_ren, Rt_reg_ren,
        output Rs_token, Rt_token, Rs_Data_spec, Rt_Data_spec, Rs_Data_valid, Rt_Data_valid,
        input  Cdb_valid, Cdb_rd_tag, Cdb_data, Cdb_branch, Cdb_branch_taken,
        output Retire_valid, Retire_rd_tag, Retire_rd_reg, Retire_data, Retire_pc,
        output Retire_branch, Retire_branch_taken, Retire_store_ready
    );
endinterface

// File: rtl/rob_unit.sv
// Reorder buffer: register status table, tag-indexed result file and a
// program-order tag FIFO. Retires completed instructions in dispatch order,
// at most one per clock. Mispredictions are only reported; flush is by reset.
module rob_unit #(
    parameter int ENTRIES = 32,
    parameter int NREGS   = 32
) (
    input logic     clock,
    input logic     reset,
    rob_unit_if.slave rob
);
    localparam logic [5:0] FULL_COUNT = 6'(ENTRIES);
    localparam logic [1:0] TYPE_RD     = 2'b00;
    localparam logic [1:0] TYPE_BRANCH = 2'b01;
    localparam logic [1:0] TYPE_STORE  = 2'b10;

    // Register status table: latest in-flight tag per architectural register
    logic [4:0]       rst_tag_q   [NREGS];
    logic [4:0]       rst_tag_d   [NREGS];
    logic [NREGS-1:0] rst_valid_q, rst_valid_d;

    // Result file, indexed by tag
    logic [4:0]         ent_reg_q  [ENTRIES];
    logic [4:0]         ent_reg_d  [ENTRIES];
    logic [31:0]        ent_pc_q   [ENTRIES];
    logic [31:0]        ent_pc_d   [ENTRIES];
    logic [1:0]         ent_type_q [ENTRIES];
    logic [1:0]         ent_type_d [ENTRIES];
    logic [31:0]        ent_data_q [ENTRIES];
    logic [31:0]        ent_data_d [ENTRIES];
    logic [ENTRIES-1:0] ent_valid_q, ent_valid_d;
    logic [ENTRIES-1:0] ent_done_q,  ent_done_d;
    logic [ENTRIES-1:0] ent_taken_q, ent_taken_d;

    // Program-order tag FIFO
    logic [4:0] fifo_q [ENTRIES];
    logic [4:0] fifo_d [ENTRIES];
    logic [4:0] head_q, head_d;
    logic [4:0] tail_q, tail_d;
    logic [5:0] count_q, count_d;

    // Registered retire outputs
    logic        ret_valid_q,  ret_valid_d;
    logic [4:0]  ret_tag_q,    ret_tag_d;
    logic [4:0]  ret_reg_q,    ret_reg_d;
    logic [31:0] ret_data_q,   ret_data_d;
    logic [31:0] ret_pc_q,     ret_pc_d;
    logic        ret_branch_q, ret_branch_d;
    logic        ret_taken_q,  ret_taken_d;
    logic        ret_store_q,  ret_store_d;

    logic       full;
    logic       dispatch_en;
    logic       retire_en;
    logic [4:0] head_tag;
    logic [4:0] head_reg;

    // Next-state: CDB write, then retire, then dispatch, so dispatch has the
    // final say on both the entry (done = 0) and the RST mapping.
    always_comb begin
        rst_tag_d    = rst_tag_q;
        rst_valid_d  = rst_valid_q;
        ent_reg_d    = ent_reg_q;
        ent_pc_d     = ent_pc_q;
        ent_type_d   = ent_type_q;
        ent_data_d   = ent_data_q;
        ent_valid_d  = ent_valid_q;
        ent_done_d   = ent_done_q;
        ent_taken_d  = ent_taken_q;
        fifo_d       = fifo_q;
        head_d       = head_q;
        tail_d       = tail_q;
        ret_valid_d  = 1'b0;
        ret_tag_d    = ret_tag_q;
        ret_reg_d    = ret_reg_q;
        ret_data_d   = ret_data_q;
        ret_pc_d     = ret_pc_q;
        ret_branch_d = ret_branch_q;
        ret_taken_d  = ret_taken_q;
        ret_store_d  = ret_store_q;

        full        = (count_q == FULL_COUNT);
        dispatch_en = rob.Dispatch_valid && !full;
        head_tag    = fifo_q[head_q];
        head_reg    = ent_reg_q[head_tag];
        // Uses the registered done flag, so a completion becomes eligible
        // one edge after its CDB write.
        retire_en   = (count_q != 6'd0) && ent_done_q[head_tag];

        if (rob.Cdb_valid && ent_valid_q[rob.Cdb_rd_tag]) begin
            ent_data_d[rob.Cdb_rd_tag]  = rob.Cdb_data;
            ent_done_d[rob.Cdb_rd_tag]  = 1'b1;
            ent_taken_d[rob.Cdb_rd_tag] = rob.Cdb_branch & rob.Cdb_branch_taken;
        end

        if (retire_en) begin
            ent_valid_d[head_tag] = 1'b0;
            ent_done_d[head_tag]  = 1'b0;
            head_d       = head_q + 5'd1;
            ret_valid_d  = 1'b1;
            ret_tag_d    = head_tag;
            ret_reg_d    = head_reg;
            ret_data_d   = ent_data_q[head_tag];
            ret_pc_d     = ent_pc_q[head_tag];
            ret_branch_d = (ent_type_q[head_tag] == TYPE_BRANCH);
            ret_taken_d  = ent_taken_q[head_tag];
            ret_store_d  = (ent_type_q[head_tag] == TYPE_STORE);
            // Only drop the mapping if no younger instruction renamed it
            if (rst_valid_q[head_reg] && (rst_tag_q[head_reg] == head_tag)) begin
                rst_valid_d[head_reg] = 1'b0;
            end
        end

        if (dispatch_en) begin
            fifo_d[tail_q] = rob.Dispatch_Rd_tag;
            tail_d         = tail_q + 5'd1;
            ent_reg_d[rob.Dispatch_Rd_tag]   = rob.Dispatch_Rd_reg;
            ent_pc_d[rob.Dispatch_Rd_tag]    = rob.Dispatch_pc;
            ent_type_d[rob.Dispatch_Rd_tag]  = rob.Dispatch_inst_type;
            ent_data_d[rob.Dispatch_Rd_tag]  = 32'd0;
            ent_valid_d[rob.Dispatch_Rd_tag] = 1'b1;
            ent_done_d[rob.Dispatch_Rd_tag]  = 1'b0;
            ent_taken_d[rob.Dispatch_Rd_tag] = 1'b0;
            // Reserved type 11 behaves like 00 but never renames; r0 is never renamed
            if ((rob.Dispatch_inst_type == TYPE_RD) && (rob.Dispatch_Rd_reg != 5'd0)) begin
                rst_tag_d[rob.Dispatch_Rd_reg]   = rob.Dispatch_Rd_tag;
                rst_valid_d[rob.Dispatch_Rd_reg] = 1'b1;
            end
        end

        count_d = count_q + {5'd0, dispatch_en} - {5'd0, retire_en};
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            rst_tag_q    <= '{default: '0};
            rst_valid_q  <= '0;
            ent_reg_q    <= '{default: '0};
            ent_pc_q     <= '{default: '0};
            ent_type_q   <= '{default: '0};
            ent_data_q   <= '{default: '0};
            ent_valid_q  <= '0;
            ent_done_q   <= '0;
            ent_taken_q  <= '0;
            fifo_q       <= '{default: '0};
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            ret_valid_q  <= 1'b0;
            ret_tag_q    <= '0;
            ret_reg_q    <= '0;
            ret_data_q   <= '0;
            ret_pc_q     <= '0;
            ret_branch_q <= 1'b0;
            ret_taken_q  <= 1'b0;
            ret_store_q  <= 1'b0;
        end else begin
            rst_tag_q    <= rst_tag_d;
            rst_valid_q  <= rst_valid_d;
            ent_reg_q    <= ent_reg_d;
            ent_pc_q     <= ent_pc_d;
            ent_type_q   <= ent_type_d;
            ent_data_q   <= ent_data_d;
            ent_valid_q  <= ent_valid_d;
            ent_done_q   <= ent_done_d;
            ent_taken_q  <= ent_taken_d;
            fifo_q       <= fifo_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            ret_valid_q  <= ret_valid_d;
            ret_tag_q    <= ret_tag_d;
            ret_reg_q    <= ret_reg_d;
            ret_data_q   <= ret_data_d;
            ret_pc_q     <= ret_pc_d;
            ret_branch_q <= ret_branch_d;
            ret_taken_q  <= ret_taken_d;
            ret_store_q  <= ret_store_d;
        end
    end

    // Source-operand query ports: index 0 is Rs, index 1 is Rt
    logic [4:0] q_reg [2];
    logic [1:0] q_ren;

    assign q_reg[0] = rob.Rs_reg;
    assign q_reg[1] = rob.Rt_reg;
    assign q_ren    = {rob.Rt_reg_ren, rob.Rs_reg_ren};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_query
            logic [5:0]  token;
            logic [31:0] data;
            logic        dvalid;
            logic [4:0]  map_tag;

            // Look up the mapping from registered state only (no same-cycle bypass)
            always_comb begin
                token   = '0;
                data    = '0;
                dvalid  = 1'b0;
                map_tag = rst_tag_q[q_reg[gi]];
                if (q_ren[gi]) begin
                    token  = {map_tag, rst_valid_q[q_reg[gi]]};
                    data   = ent_data_q[map_tag];
                    dvalid = rst_valid_q[q_reg[gi]] & ent_done_q[map_tag];
                end
            end
        end
    endgenerate

    assign rob.Rs_token      = g_query[0].token;
    assign rob.Rs_Data_spec  = g_query[0].data;
    assign rob.Rs_Data_valid = g_query[0].dvalid;
    assign rob.Rt_token      = g_query[1].token;
    assign rob.Rt_Data_spec  = g_query[1].data;
    assign rob.Rt_Data_valid = g_query[1].dvalid;

    assign rob.Rob_full            = full;
    assign rob.Retire_valid        = ret_valid_q;
    assign rob.Retire_rd_tag       = ret_tag_q;
    assign rob.Retire_rd_reg       = ret_reg_q;
    assign rob.Retire_data         = ret_data_q;
    assign rob.Retire_pc           = ret_pc_q;
    assign rob.Retire_branch       = ret_branch_q;
    assign rob.Retire_branch_taken = ret_taken_q;
    assign rob.Retire_store_ready  = ret_store_q;
endmodule

// File: tb/tb_rob_unit.sv
// Self-checking bench for rob_unit. Accepted dispatches are pushed to a
// scoreboard queue; every retire pulse pops it and is compared with the
// bench's own record of that tag.
module tb_rob_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rob_unit_if bus();

    rob_unit u_dut (
        .clock (clk),
        .reset (rst),
        .rob   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Scoreboard and per-tag model
    int          sb_q [$];
    logic [4:0]  m_reg   [32];
    logic [31:0] m_pc    [32];
    logic [31:0] m_data  [32];
    logic [1:0]  m_type  [32];
    logic        m_taken [32];
    logic        m_valid [32];
    int          ret_cyc [32];
    int          last_cdb_cyc = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Retire monitor: one line per retired instruction
    initial begin
        int t;
        forever begin
            @(negedge clk);
            if (!rst && bus.Retire_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("spurious_retire", 1, 0);
                end else begin
                    t = sb_q.pop_front();
                    $display("retire tag=%0d reg=%0d data=%h pc=%h br=%0b tk=%0b st=%0b",
                             bus.Retire_rd_tag, bus.Retire_rd_reg, bus.Retire_data, bus.Retire_pc,
                             bus.Retire_branch, bus.Retire_branch_taken, bus.Retire_store_ready);
                    check("ret_tag",   bus.Retire_rd_tag, t);
                    check("ret_reg",   bus.Retire_rd_reg, m_reg[t]);
                    check("ret_data",  bus.Retire_data, m_data[t]);
                    check("ret_pc",    bus.Retire_pc, m_pc[t]);
                    check("ret_br",    bus.Retire_branch, m_type[t] == 2'b01);
                    check("ret_taken", bus.Retire_branch_taken, m_taken[t]);
                    check("ret_store", bus.Retire_store_ready, m_type[t] == 2'b10);
                    m_valid[t] = 1'b0;
                    ret_cyc[t] = cyc;
                end
            end
        end
    end

    task automatic dispatch(input logic [4:0] tag, input logic [4:0] rd,
                            input logic [31:0] pc, input logic [1:0] typ);
        bus.Dispatch_valid     = 1'b1;
        bus.Dispatch_Rd_tag    = tag;
        bus.Dispatch_Rd_reg    = rd;
        bus.Dispatch_pc        = pc;
        bus.Dispatch_inst_type = typ;
        if (sb_q.size() < 32) begin
            sb_q.push_back(int'(tag));
            m_reg[tag]   = rd;
            m_pc[tag]    = pc;
            m_type[tag]  = typ;
            m_data[tag]  = 32'd0;
            m_taken[tag] = 1'b0;
            m_valid[tag] = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.Dispatch_valid = 1'b0;
    endtask

    task automatic cdb(input logic [4:0] tag, input logic [31:0] data,
                       input logic br, input logic tk);
        bus.Cdb_valid        = 1'b1;
        bus.Cdb_rd_tag       = tag;
        bus.Cdb_data         = data;
        bus.Cdb_branch       = br;
        bus.Cdb_branch_taken = tk;
        if (m_valid[tag]) begin
            m_data[tag]  = data;
            m_taken[tag] = br & tk;
        end
        @(posedge clk);
        #1;
        bus.Cdb_valid = 1'b0;
        last_cdb_cyc  = cyc;
    endtask

    task automatic query_rs(input logic [4:0] r, input logic ren);
        bus.Rs_reg     = r;
        bus.Rs_reg_ren = ren;
        #1;
    endtask

    task automatic query_rt(input logic [4:0] r, input logic ren);
        bus.Rt_reg     = r;
        bus.Rt_reg_ren = ren;
        #1;
    endtask

    task automatic wait_left(input int left, input int budget);
        for (int i = 0; i < budget && sb_q.size() != left; i++) begin
            @(negedge clk);
            #1;
        end
        check("drain", sb_q.size(), left);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c1;
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            ret_cyc[i] = 0;
        end
        bus.Dispatch_valid = 0; bus.Dispatch_Rd_tag = 0; bus.Dispatch_Rd_reg = 0;
        bus.Dispatch_pc = 0; bus.Dispatch_inst_type = 0;
        bus.Rs_reg = 0; bus.Rt_reg = 0; bus.Rs_reg_ren = 0; bus.Rt_reg_ren = 0;
        bus.Cdb_valid = 0; bus.Cdb_rd_tag = 0; bus.Cdb_data = 0;
        bus.Cdb_branch = 0; bus.Cdb_branch_taken = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        query_rs(5'd3, 1'b1);
        check("rst_token", bus.Rs_token, 6'd0);
        check("rst_dvalid", bus.Rs_Data_valid, 0);
        check("rst_full", bus.Rob_full, 0);
        check("rst_retv", bus.Retire_valid, 0);
        check("rst_ret_data", bus.Retire_data, 0);

        // Single instruction: rename, complete, retire, mapping released
        dispatch(5'd5, 5'd3, 32'h100, 2'b00);
        query_rs(5'd3, 1'b1);
        check("r3_token", bus.Rs_token, {5'd5, 1'b1});
        check("r3_dvalid0", bus.Rs_Data_valid, 0);
        query_rt(5'd3, 1'b1);
        check("rt_token", bus.Rt_token, {5'd5, 1'b1});
        query_rs(5'd3, 1'b0);
        check("ren0_token", bus.Rs_token, 0);
        cdb(5'd5, 32'h1234, 1'b0, 1'b0);
        query_rs(5'd3, 1'b1);
        check("r3_spec", bus.Rs_Data_spec, 32'h1234);
        check("r3_dvalid1", bus.Rs_Data_valid, 1);
        check("no_bypass", bus.Retire_valid, 0);
        @(posedge clk);
        #1;
        check("retire_pulse", bus.Retire_valid, 1);
        @(posedge clk);
        #1;
        check("pulse_end", bus.Retire_valid, 0);
        check("hold_tag", bus.Retire_rd_tag, 5);
        query_rs(5'd3, 1'b1);
        check("r3_released", bus.Rs_token[0], 0);

        // Out-of-order completion, in-order retirement on consecutive cycles
        dispatch(5'd1, 5'd10, 32'h200, 2'b00);
        dispatch(5'd2, 5'd11, 32'h204, 2'b00);
        dispatch(5'd3, 5'd12, 32'h208, 2'b00);
        cdb(5'd3, 32'h33, 1'b0, 1'b0);
        cdb(5'd2, 32'h22, 1'b0, 1'b0);
        check("ooo_hold", bus.Retire_valid, 0);
        cdb(5'd1, 32'h11, 1'b0, 1'b0);
        c1 = last_cdb_cyc;
        wait_left(0, 20);
        check("ord1_lat", ret_cyc[1] - c1, 1);
        check("ord2_lat", ret_cyc[2] - ret_cyc[1], 1);
        check("ord3_lat", ret_cyc[3] - ret_cyc[2], 1);

        // Branch taken, branch not taken, store
        dispatch(5'd7, 5'd0, 32'h400, 2'b01);
        cdb(5'd7, 32'hBEEF, 1'b1, 1'b1);
        wait_left(0, 10);
        check("br_pc", bus.Retire_pc, 32'h400);
        check("br_taken", bus.Retire_branch_taken, 1);
        dispatch(5'd9, 5'd0, 32'h480, 2'b01);
        cdb(5'd9, 32'h0, 1'b1, 1'b0);
        wait_left(0, 10);
        dispatch(5'd8, 5'd0, 32'h404, 2'b10);
        cdb(5'd8, 32'h0, 1'b0, 1'b0);
        wait_left(0, 10);
        check("store_ready", bus.Retire_store_ready, 1);

        // Reserved type does not rename; r0 never renamed
        dispatch(5'd10, 5'd6, 32'h500, 2'b11);
        query_rs(5'd6, 1'b1);
        check("rsv_norename", bus.Rs_token[0], 0);
        dispatch(5'd11, 5'd0, 32'h504, 2'b00);
        query_rs(5'd0, 1'b1);
        check("r0_token", bus.Rs_token, 0);
        cdb(5'd10, 32'hA10, 1'b0, 1'b0);
        cdb(5'd11, 32'hA11, 1'b0, 1'b0);
        wait_left(0, 10);

        // Broadcast to an idle tag is ignored
        cdb(5'd20, 32'h77, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("stale_ignored", bus.Retire_valid, 0);

        // Dispatch and CDB to the same tag in one cycle: dispatch wins
        bus.Dispatch_valid = 1'b1; bus.Dispatch_Rd_tag = 5'd20; bus.Dispatch_Rd_reg = 5'd7;
        bus.Dispatch_pc = 32'h600; bus.Dispatch_inst_type = 2'b00;
        bus.Cdb_valid = 1'b1; bus.Cdb_rd_tag = 5'd20; bus.Cdb_data = 32'h99;
        bus.Cdb_branch = 1'b0; bus.Cdb_branch_taken = 1'b0;
        sb_q.push_back(20);
        m_reg[20] = 5'd7; m_pc[20] = 32'h600; m_type[20] = 2'b00;
        m_data[20] = 32'd0; m_taken[20] = 1'b0; m_valid[20] = 1'b1;
        @(posedge clk);
        #1;
        bus.Dispatch_valid = 1'b0;
        bus.Cdb_valid = 1'b0;
        query_rs(5'd7, 1'b1);
        check("disp_wins_tok", bus.Rs_token, {5'd20, 1'b1});
        check("disp_wins_done", bus.Rs_Data_valid, 0);
        cdb(5'd20, 32'h55, 1'b0, 1'b0);
        wait_left(0, 10);

        // Younger rename survives retirement of the older writer
        dispatch(5'd1, 5'd4, 32'h700, 2'b00);
        dispatch(5'd2, 5'd4, 32'h704, 2'b00);
        cdb(5'd1, 32'h41, 1'b0, 1'b0);
        wait_left(1, 10);
        query_rs(5'd4, 1'b1);
        check("r4_younger", bus.Rs_token, {5'd2, 1'b1});
        cdb(5'd2, 32'h42, 1'b0, 1'b0);
        wait_left(0, 10);
        query_rs(5'd4, 1'b1);
        check("r4_released", bus.Rs_token[0], 0);

        // Fill to 32, reject while full, free one, pointers wrap
        for (int t = 0; t < 32; t++) begin
            dispatch(5'(t), 5'(t), 32'h1000 + 32'(t) * 4, 2'b00);
        end
        check("full_set", bus.Rob_full, 1);
        dispatch(5'd0, 5'd9, 32'hDEAD, 2'b00);
        check("full_hold", bus.Rob_full, 1);
        query_rs(5'd9, 1'b1);
        check("reject_rst", bus.Rs_token, {5'd9, 1'b1});
        cdb(5'd0, 32'hA0, 1'b0, 1'b0);
        // Retire of tag 0 lands on the same edge: still rejected
        dispatch(5'd0, 5'd9, 32'hBEEF, 2'b00);
        check("full_clear", bus.Rob_full, 0);
        query_rs(5'd9, 1'b1);
        check("reject_rst2", bus.Rs_token, {5'd9, 1'b1});
        @(negedge clk);
        #1;
        dispatch(5'd0, 5'd0, 32'h2000, 2'b01);
        check("refull", bus.Rob_full, 1);
        for (int t = 1; t < 32; t++) begin
            cdb(5'(t), 32'h100 + 32'(t), 1'b0, 1'b0);
        end
        cdb(5'd0, 32'hC0, 1'b1, 1'b0);
        wait_left(0, 100);
        check("empty_full", bus.Rob_full, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
